key_encoder83: RTL and testbench

Debounced 8-to-3 priority encoder for the board's eight push-buttons; it is the input-side counterpart of the 3-to-8 one-hot decoder that drives the LEDs and digit selects. Raw button levels are synchronised and debounced. The highest-numbered pressed key is encoded to a 3-bit code and held until release, with a one-cycle press strobe. The code uses the same numbering the decoder consumes, so key n drives code n back into the decoder.

---
 rtl/key_pkg.sv | 16 +
 rtl/sync2.sv | 20 ++
 rtl/key_encoder83.sv | 90 +++++++++
 tb/tb_key_encoder83.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared types and helpers for the key encoder and the LED/digit decoder.
package key_pkg;
   localparam int KEYS = 8;
   localparam int CODE_W = 3;
   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
   // Index of the highest set bit; callers never pass an all-zero vector.
   function automatic logic [CODE_W-1:0] prio8(input logic [KEYS-1:0] v);
      logic [CODE_W-1:0] r;
      r = '0;
      for (int i = 0; i < KEYS; i++) if (v[i]) r = i[CODE_W-1:0];
      return r;
   endfunction
   function automatic logic popcnt_gt1(input logic [KEYS-1:0] v);
      return (v & (v - 8'd1)) != '0;
   endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for asynchronous level inputs.
module sync2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] meta_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         q_o    <= '0;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end
endmodule

// File: rtl/key_encoder83.sv
// key_encoder83: debounced 8-to-3 priority encoder for the push-buttons.
// The code is frozen at acceptance and held until the release is debounced.
module key_encoder83
   import key_pkg::*;
#(
   parameter int DEB_CYCLES = 50000,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [KEYS-1:0]   key_i,
   output logic [CODE_W-1:0] code_o,
   output logic              valid_o,
   output logic              press_o,
   output logic              multi_o
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
   logic [KEYS-1:0]   ks, snap_q, snap_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   state_t            state_q, state_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              valid_q, valid_d, press_q, press_d, multi_q, multi_d;
   sync2 #(.W(KEYS)) u_sync (.clk(clk), .rst_n(rst_n), .d_i(key_i), .q_o(ks));
   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      valid_d = valid_q;
      multi_d = multi_q;
      press_d = 1'b0;
      case (state_q)
         IDLE: if (ks != '0) begin
            snap_d  = ks;
            cnt_d   = '0;
            state_d = DEBOUNCE;
         end
         DEBOUNCE: if (ks != snap_q) begin
            state_d = (ks == '0) ? IDLE : DEBOUNCE;
            snap_d  = ks;
            cnt_d   = '0;
         end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            code_d  = prio8(snap_q);
            multi_d = popcnt_gt1(snap_q);
            valid_d = 1'b1;
            press_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         PRESSED: if (ks == '0) begin
            cnt_d   = '0;
            state_d = RELEASE;
         end
         // Keys coming back before the window expires count as release bounce.
         RELEASE: if (ks != '0) begin
            state_d = PRESSED;
         end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            valid_d = 1'b0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         snap_q  <= '0;
         cnt_q   <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         press_q <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         press_q <= press_d;
         multi_q <= multi_d;
      end
   end
   assign code_o  = code_q;
   assign valid_o = valid_q;
   assign press_o = press_q;
   assign multi_o = multi_q;
endmodule

// File: tb/tb_key_encoder83.sv
// tb_key_encoder83: directed table-driven checks of the debounced key encoder.
module tb_key_encoder83;
   localparam int DEB = 4;
   localparam int LAT = DEB + 2;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] key_i = 8'h00;
   logic [2:0] code_o;
   logic       valid_o, press_o, multi_o;
   int n_checks = 0;
   int n_fail = 0;
   int presses = 0;

   key_encoder83 #(.DEB_CYCLES(DEB), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .key_i(key_i),
      .code_o(code_o), .valid_o(valid_o), .press_o(press_o), .multi_o(multi_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] key;
      logic [2:0] code;
      logic       multi;
   } vec_t;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Advance one rising edge and sample at the following falling edge.
   task automatic step();
      @(negedge clk);
      if (press_o) presses++;
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, " code"}, code_o, 0);
      check({name, " valid"}, valid_o, 0);
      check({name, " press"}, press_o, 0);
      check({name, " multi"}, multi_o, 0);
   endtask

   // Key already driven before edge E0; expect press registered at edge E0+LAT.
   task automatic expect_press(input string name, input logic [2:0] code, input logic multi);
      presses = 0;
      for (int i = 0; i < LAT; i++) step();
      check({name, " early press"}, presses, 0);
      check({name, " early valid"}, valid_o, 0);
      step();
      check({name, " press"}, press_o, 1);
      check({name, " valid"}, valid_o, 1);
      check({name, " code"}, code_o, code);
      check({name, " multi"}, multi_o, multi);
      step();
      check({name, " press width"}, press_o, 0);
   endtask

   task automatic expect_release(input string name, input logic [2:0] code, input logic multi);
      key_i = 8'h00;
      presses = 0;
      for (int i = 0; i < LAT; i++) step();
      check({name, " valid held"}, valid_o, 1);
      step();
      check({name, " valid drop"}, valid_o, 0);
      check({name, " code kept"}, code_o, code);
      check({name, " multi kept"}, multi_o, multi);
      check({name, " no press"}, presses, 0);
      for (int i = 0; i < 3; i++) step();
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{8'h08, 3'd3, 1'b0};
      vecs[1] = '{8'h01, 3'd0, 1'b0};
      vecs[2] = '{8'h80, 3'd7, 1'b0};
      vecs[3] = '{8'hFF, 3'd7, 1'b1};
      vecs[4] = '{8'h81, 3'd7, 1'b1};
      vecs[5] = '{8'h24, 3'd5, 1'b1};

      #2;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step();

      foreach (vecs[k]) begin
         key_i = vecs[k].key;
         expect_press($sformatf("vec%0d", k), vecs[k].code, vecs[k].multi);
         expect_release($sformatf("vec%0d rel", k), vecs[k].code, vecs[k].multi);
      end

      // Bounce: short pulses never survive the window, final hold gives one press.
      presses = 0;
      for (int s = 0; s < 6; s++) begin
         key_i = (s % 2 == 0) ? 8'h20 : 8'h00;
         step();
         step();
      end
      check("bounce no early press", presses, 0);
      key_i = 8'h20;
      expect_press("bounce", 3'd5, 1'b0);
      for (int i = 0; i < 8; i++) step();
      check("bounce single press", presses, 1);
      expect_release("bounce rel", 3'd5, 1'b0);

      // Priority frozen while held.
      key_i = 8'h81;
      expect_press("prio", 3'd7, 1'b1);
      key_i = 8'h01;
      presses = 0;
      for (int i = 0; i < 10; i++) step();
      check("prio frozen code", code_o, 7);
      check("prio frozen multi", multi_o, 1);
      check("prio no repress", presses, 0);
      check("prio valid", valid_o, 1);
      expect_release("prio rel", 3'd7, 1'b1);

      // Release glitch shorter than the window.
      key_i = 8'h04;
      expect_press("glitch", 3'd2, 1'b0);
      key_i = 8'h00;
      step();
      step();
      key_i = 8'h04;
      presses = 0;
      begin
         int valid_low = 0;
         for (int i = 0; i < 12; i++) begin
            step();
            if (!valid_o) valid_low++;
         end
         check("glitch valid low cycles", valid_low, 0);
      end
      check("glitch no repress", presses, 0);
      expect_release("glitch rel", 3'd2, 1'b0);

      // Reset during DEBOUNCE after a press left code_o nonzero.
      key_i = 8'h40;
      expect_press("pre", 3'd6, 1'b0);
      expect_release("pre rel", 3'd6, 1'b0);
      key_i = 8'h10;
      for (int i = 0; i < 4; i++) step();
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("rst deb");
      @(negedge clk);
      rst_n = 1'b1;
      expect_press("after rst deb", 3'd4, 1'b0);

      // Reset during PRESSED with key still held.
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("rst prs");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      expect_press("after rst prs", 3'd4, 1'b0);
      expect_release("after rst rel", 3'd4, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
